chunked_adder: RTL and testbench

//  Parametrised multi-cycle adder/accumulate datapath; successor to the fixed 4-bit ripple adder.

---
 rtl/chunked_adder_pkg.sv | 10 +
 rtl/chunked_adder_chunk_add.sv | 21 ++
 rtl/chunked_adder.sv | 93 +++++++++
 tb/tb_chunked_adder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/chunked_adder_pkg.sv
// chunked_adder_pkg: shared FSM state type and sizing helpers for chunked_adder
package chunked_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nchunk(int w, int c);
    return w / c;
  endfunction
  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chunked_adder_chunk_add.sv
// chunk_add: combinational CHUNK-bit ripple adder; c_msb is the carry into the top bit (for overflow)
// Ports: a, b (CHUNK) operands; ci carry in; s (CHUNK) sum; co carry out; c_msb carry into bit CHUNK-1
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [CHUNK:0] w_c;
  always_comb begin
    w_c[0] = ci;
    for (int i = 0; i < CHUNK; i++) w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end
  assign s     = a ^ b ^ w_c[CHUNK-1:0];
  assign co    = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];
endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder, CHUNK bits per cycle LSB first, valid/ready on both sides
// Ports: clk, rst_n (async active-low); in_valid/in_ready, x, y, cin, sub (only with
// CHUNKED_ADDER_SUB_EN) on the input side; out_valid/out_ready, sum, cout, ovf on the output side.
// Optional macro CHUNKED_ADDER_SUB_EN adds the sub port: sum = x - y - cin, cout=1 means no borrow.
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NC = nchunk(WIDTH, CHUNK);
  localparam int CW = cnt_w(NC);
  localparam logic [CW-1:0] LAST = CW'(NC - 1);
  if (WIDTH % CHUNK != 0) begin : g_chk
    $error("chunked_adder: WIDTH must be a multiple of CHUNK");
  end
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_x, r_y, r_sum;
  logic             r_c, r_cout, r_ovf;
  logic [CHUNK-1:0] w_s;
  logic             w_co, w_c_msb, w_sub;
`ifdef CHUNKED_ADDER_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif
  chunk_add #(.CHUNK(CHUNK)) u_add (
    .a(r_x[r_cnt*CHUNK +: CHUNK]),
    .b(r_y[r_cnt*CHUNK +: CHUNK]),
    .ci(r_c),
    .s(w_s),
    .co(w_co),
    .c_msb(w_c_msb)
  );
  // Subtraction is folded in at capture: y is stored inverted and the carry seed is ~cin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_c     <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_x     <= x;
        r_y     <= w_sub ? ~y : y;
        r_c     <= cin ^ w_sub;
        r_cnt   <= '0;
        r_state <= RUN;
      end
    end else if (r_state == RUN) begin
      r_sum[r_cnt*CHUNK +: CHUNK] <= w_s;
      r_c <= w_co;
      if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_cout  <= w_co;
        r_ovf   <= w_c_msb ^ w_co;
        r_state <= DONE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (r_state == DONE) begin
      if (out_ready) r_state <= IDLE;
    end else begin
      r_state <= IDLE;
    end
  end
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed and random checks of chunked_adder against an arithmetic model
module tb_chunked_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sb = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic in_ready, out_valid, cout, ovf;
  logic [15:0] sum;
  logic in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
  logic [3:0] x4 = '0, y4 = '0;
  logic in_ready4, out_valid4, cout4, ovf4;
  logic [3:0] sum4;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub(sb),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  chunked_adder #(.WIDTH(4), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .x(x4), .y(y4), .cin(cin4),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ovf, cout, sum} from the arithmetic definition: x + y' + c, with y' = ~y and c = ~cin for subtract
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic s);
    logic [15:0] bb;
    logic        cc;
    logic [16:0] t;
    int          r;
    bb = s ? ~b : b;
    cc = s ? ~ci : ci;
    t  = {1'b0, a} + {1'b0, bb} + 17'(cc);
    r  = int'($signed(a)) + int'($signed(bb)) + int'(cc);
    return {(r > 32767 || r < -32768), t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic s, input int hold);
    logic [17:0] e;
    int n;
    e = model(a, b, ci, s);
    chk("in_ready_before", 32'(in_ready), 32'd1);
    x = a; y = b; cin = ci; sb = s; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    chk("sum", 32'(sum), 32'(e[15:0]));
    chk("cout", 32'(cout), 32'(e[16]));
    chk("ovf", 32'(ovf), 32'(e[17]));
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      x = 16'($urandom);
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_sum", 32'({cout, sum}), 32'(e[16:0]));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", 32'({ovf, cout, sum}), 32'd0);
    rst_n = 1'b1;
    tick();
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
    chk("t1_sum", 32'(sum), 32'h0100);
    run_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, 0);
    chk("t2a_sum", 32'({ovf, cout, sum}), 32'h10001);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    chk("t2b_sum", 32'({ovf, cout, sum}), 32'h28000);
    // single-chunk instance
    x4 = 4'b1011; y4 = 4'b1111; cin4 = 1'b0; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 10) begin
      tick();
      n++;
    end
    chk("t3_latency", 32'(n), 32'd1);
    chk("t3_sum", 32'(sum4), 32'hA);
    chk("t3_cout", 32'(cout4), 32'd1);
    chk("t3_ovf", 32'(ovf4), 32'd0);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    chk("t3_release", 32'({in_ready4, out_valid4}), 32'b10);
    run_op(16'hA5A5, 16'h1234, 1'b1, 1'b0, 10);
    // reset two edges into RUN
    x = 16'hFFFF; y = 16'h0001; cin = 1'b1; sb = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_outs", 32'({ovf, cout, sum}), 32'd0);
    tick();
    chk("t5_held", 32'({out_valid, ovf, cout, sum}), 32'd0);
    rst_n = 1'b1;
    tick();
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
    chk("t5_sum", 32'(sum), 32'h2345);
`ifdef CHUNKED_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    chk("t6_sub", 32'({ovf, cout, sum}), 32'h0FFFE);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
    chk("t6_add", 32'(sum), 32'h0100);
`endif
    for (int i = 0; i < 16; i++) begin
`ifdef CHUNKED_ADDER_SUB_EN
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
`else
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, $urandom_range(0, 3));
`endif
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
